// File: rtl/secuenciador_cafe_if.sv
// Handshake and configuration bundle between maquina_cafe and secuenciador_cafe.
// Carries total_bebidas only when CONTADOR_BEBIDAS_EN is defined.
interface secuenciador_cafe_if;
  logic       inicio;
  logic       cancelar;
  logic [1:0] tipo_cafe;
  logic [1:0] tamano;
  logic [3:0] nivel_azucar;
  logic       concentracion;
  logic       leche;
  logic       espuma;

  logic       ocupado;
  logic       listo;
  logic       moler;
  logic       agua;
  logic       dosis_azucar;
  logic       valvula_leche;
  logic       vapor_espuma;
  logic [1:0] tipo_activo;
`ifdef CONTADOR_BEBIDAS_EN
  logic [15:0] total_bebidas;
`endif

  modport master (
`ifdef CONTADOR_BEBIDAS_EN
    input  total_bebidas,
`endif
    output inicio, cancelar, tipo_cafe, tamano, nivel_azucar, concentracion, leche, espuma,
    input  ocupado, listo, moler, agua, dosis_azucar, valvula_leche, vapor_espuma, tipo_activo
  );

  modport slave (
`ifdef CONTADOR_BEBIDAS_EN
    output total_bebidas,
`endif
    input  inicio, cancelar, tipo_cafe, tamano, nivel_azucar, concentracion, leche, espuma,
    output ocupado, listo, moler, agua, dosis_azucar, valvula_leche, vapor_espuma, tipo_activo
  );
endinterface

// File: rtl/secuenciador_cafe.sv
// Coffee actuator sequencer: grind, water, sugar, milk, foam, then a one-cycle listo pulse.
// Optional CONTADOR_BEBIDAS_EN adds a saturating completed-drink counter (total_bebidas).
module secuenciador_cafe #(
  parameter int T_MOLER    = 4,
  parameter int T_AGUA     = 8,
  parameter int T_LECHE    = 6,
  parameter int T_ESPUMA   = 3,
  parameter int MAX_AZUCAR = 10
) (
  input logic               clock,
  input logic               reset,
  secuenciador_cafe_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MOLER, AGUA, AZUCAR, LECHE, ESPUMA, FIN} estado_t;

  // Configuration is stored already clamped so the phase logic never sees illegal sizes/doses.
  typedef struct packed {
    logic [1:0] tipo;
    logic [1:0] tam;
    logic [3:0] dosis;
    logic       conc;
    logic       leche;
    logic       espuma;
  } cfg_t;

  estado_t    estado, estado_nxt;
  logic [7:0] cnt, cnt_nxt;
  cfg_t       cfg, cfg_nxt, cfg_in;

  logic       ocupado_q, listo_q, moler_q, agua_q, dosis_q, leche_q, espuma_q;
  logic [1:0] tipo_q;

  // Phase duration minus one, loaded into the counter on phase entry.
  function automatic logic [7:0] carga(estado_t e, cfg_t c);
    int d;
    case (e)
      MOLER:   d = c.conc ? 2 * T_MOLER : T_MOLER;
      AGUA:    d = T_AGUA * (int'(c.tam) + 1);
      AZUCAR:  d = 2 * int'(c.dosis);
      LECHE:   d = T_LECHE;
      ESPUMA:  d = T_ESPUMA;
      default: d = 1;
    endcase
    return 8'(d - 1);
  endfunction

  // Following phase, skipping the ones this drink does not need.
  function automatic estado_t siguiente(estado_t e, cfg_t c);
    estado_t s;
    s = FIN;
    case (e)
      MOLER:   s = AGUA;
      AGUA:    s = (c.dosis != 4'd0) ? AZUCAR : c.leche ? LECHE : c.espuma ? ESPUMA : FIN;
      AZUCAR:  s = c.leche ? LECHE : c.espuma ? ESPUMA : FIN;
      LECHE:   s = c.espuma ? ESPUMA : FIN;
      default: s = FIN;
    endcase
    return s;
  endfunction

  always_comb begin
    cfg_in.tipo   = bus.tipo_cafe;
    cfg_in.tam    = (bus.tamano == 2'd3) ? 2'd2 : bus.tamano;
    cfg_in.dosis  = (int'(bus.nivel_azucar) > MAX_AZUCAR) ? 4'(MAX_AZUCAR) : bus.nivel_azucar;
    cfg_in.conc   = bus.concentracion;
    cfg_in.leche  = bus.leche;
    cfg_in.espuma = bus.espuma;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    cfg_nxt    = cfg;
    case (estado)
      IDLE: begin
        if (bus.inicio && !bus.cancelar) begin
          estado_nxt = MOLER;
          cfg_nxt    = cfg_in;
          cnt_nxt    = carga(MOLER, cfg_in);
        end
      end
      FIN: begin
        estado_nxt = IDLE;
        cnt_nxt    = '0;
      end
      default: begin
        if (bus.cancelar) begin
          estado_nxt = IDLE;
          cnt_nxt    = '0;
        end else if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          estado_nxt = siguiente(estado, cfg);
          cnt_nxt    = carga(estado_nxt, cfg);
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change together with it.
  // NOTE: sequential state uses non-blocking assignments only; every register here is reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= IDLE;
      cnt       <= '0;
      cfg       <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      moler_q   <= 1'b0;
      agua_q    <= 1'b0;
      dosis_q   <= 1'b0;
      leche_q   <= 1'b0;
      espuma_q  <= 1'b0;
      tipo_q    <= '0;
    end else begin
      estado    <= estado_nxt;
      cnt       <= cnt_nxt;
      cfg       <= cfg_nxt;
      ocupado_q <= (estado_nxt != IDLE);
      listo_q   <= (estado_nxt == FIN);
      moler_q   <= (estado_nxt == MOLER);
      agua_q    <= (estado_nxt == AGUA);
      // Sugar counter starts odd, so odd counts are the dose cycles and even counts the gaps.
      dosis_q   <= (estado_nxt == AZUCAR) && cnt_nxt[0];
      leche_q   <= (estado_nxt == LECHE);
      espuma_q  <= (estado_nxt == ESPUMA);
      tipo_q    <= (estado_nxt != IDLE) ? cfg_nxt.tipo : 2'd0;
    end
  end

  assign bus.ocupado       = ocupado_q;
  assign bus.listo         = listo_q;
  assign bus.moler         = moler_q;
  assign bus.agua          = agua_q;
  assign bus.dosis_azucar  = dosis_q;
  assign bus.valvula_leche = leche_q;
  assign bus.vapor_espuma  = espuma_q;
  assign bus.tipo_activo   = tipo_q;

`ifdef CONTADOR_BEBIDAS_EN
  logic [15:0] total_q;

  // FIN is only reached by normal completion, so cancelled drinks never count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_q <= '0;
    end else if (estado_nxt == FIN && estado != FIN && total_q != 16'hFFFF) begin
      total_q <= total_q + 16'd1;
    end
  end

  assign bus.total_bebidas = total_q;
`endif

endmodule

// File: tb/tb_secuenciador_cafe.sv
// Self-checking bench for secuenciador_cafe: table of drinks plus cancel/reset sequences.
module tb_secuenciador_cafe;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  secuenciador_cafe_if bus ();

  secuenciador_cafe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Cycle n is the period that follows clock edge n-1; inicio is sampled at edge 0.
  typedef struct {
    logic [1:0] tipo;
    logic [1:0] tam;
    logic [3:0] az;
    logic       conc;
    logic       leche;
    logic       espuma;
    int m_last, a_last, n_dosis, d_first, d_last, l_first, l_last, e_first, e_last, listo_cyc;
  } vec_t;

  vec_t vecs[5];

  function automatic int actuators();
    return int'(bus.moler) + int'(bus.agua) + int'(bus.dosis_azucar) +
           int'(bus.valvula_leche) + int'(bus.vapor_espuma);
  endfunction

  task automatic apply_cfg(input logic [1:0] tipo, input logic [1:0] tam, input logic [3:0] az,
                           input logic conc, input logic leche, input logic espuma);
    bus.tipo_cafe     = tipo;
    bus.tamano        = tam;
    bus.nivel_azucar  = az;
    bus.concentracion = conc;
    bus.leche         = leche;
    bus.espuma        = espuma;
  endtask

  task automatic run_drink(input int idx, input vec_t v);
    int m_first = 0, m_last = 0, a_first = 0, a_last = 0;
    int n_d = 0, d_first = 0, d_last = 0;
    int l_first = 0, l_last = 0, e_first = 0, e_last = 0;
    int listo_cyc = 0, n_listo = 0, idle_cyc = 0, onehot_err = 0, tipo_err = 0;
    @(negedge clock);
    apply_cfg(v.tipo, v.tam, v.az, v.conc, v.leche, v.espuma);
    bus.cancelar = 1'b0;
    bus.inicio   = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clock);
      if (bus.moler)         begin if (m_first == 0) m_first = cyc; m_last = cyc; end
      if (bus.agua)          begin if (a_first == 0) a_first = cyc; a_last = cyc; end
      if (bus.dosis_azucar)  begin if (d_first == 0) d_first = cyc; d_last = cyc; n_d++; end
      if (bus.valvula_leche) begin if (l_first == 0) l_first = cyc; l_last = cyc; end
      if (bus.vapor_espuma)  begin if (e_first == 0) e_first = cyc; e_last = cyc; end
      if (bus.listo)         begin listo_cyc = cyc; n_listo++; end
      if (bus.listo || !bus.ocupado) begin
        if (actuators() != 0) onehot_err++;
      end else if (actuators() != 1 && !(bus.dosis_azucar == 1'b0 && d_first != 0 && l_first == 0 && e_first == 0)) begin
        onehot_err++;
      end
      if (bus.ocupado && bus.tipo_activo != v.tipo) tipo_err++;
      if (!bus.ocupado) begin
        if (bus.tipo_activo != 2'd0) tipo_err++;
        idle_cyc = cyc;
        break;
      end
      // Mid-drink: scramble configuration and pulse inicio; both must be ignored.
      bus.inicio = (cyc == 3);
      if (cyc == 3) apply_cfg(~v.tipo, ~v.tam, ~v.az, ~v.conc, ~v.leche, ~v.espuma);
    end
    bus.inicio = 1'b0;
    check($sformatf("v%0d moler_first", idx), m_first, 1);
    check($sformatf("v%0d moler_last", idx), m_last, v.m_last);
    check($sformatf("v%0d agua_first", idx), a_first, v.m_last + 1);
    check($sformatf("v%0d agua_last", idx), a_last, v.a_last);
    check($sformatf("v%0d n_dosis", idx), n_d, v.n_dosis);
    check($sformatf("v%0d dosis_first", idx), d_first, v.d_first);
    check($sformatf("v%0d dosis_last", idx), d_last, v.d_last);
    check($sformatf("v%0d leche_first", idx), l_first, v.l_first);
    check($sformatf("v%0d leche_last", idx), l_last, v.l_last);
    check($sformatf("v%0d espuma_first", idx), e_first, v.e_first);
    check($sformatf("v%0d espuma_last", idx), e_last, v.e_last);
    check($sformatf("v%0d listo_cycle", idx), listo_cyc, v.listo_cyc);
    check($sformatf("v%0d listo_count", idx), n_listo, 1);
    check($sformatf("v%0d idle_cycle", idx), idle_cyc, v.listo_cyc + 1);
    check($sformatf("v%0d actuator_errors", idx), onehot_err, 0);
    check($sformatf("v%0d tipo_errors", idx), tipo_err, 0);
  endtask

  task automatic start(input logic [1:0] tam, input logic conc);
    @(negedge clock);
    apply_cfg(2'd1, tam, 4'd0, conc, 1'b0, 1'b0);
    bus.cancelar = 1'b0;
    bus.inicio   = 1'b1;
    @(negedge clock);
    bus.inicio = 1'b0;
  endtask

  initial begin
    // tipo tam az conc leche espuma | m_last a_last n_d d_first d_last l_first l_last e_first e_last listo
    vecs[0] = '{2'd1, 2'd0, 4'd0,  1'b0, 1'b0, 1'b0, 4,  12, 0,  0,  0,  0,  0,  0,  0,  13};
    vecs[1] = '{2'd2, 2'd1, 4'd3,  1'b1, 1'b1, 1'b1, 8,  24, 3,  25, 29, 31, 36, 37, 39, 40};
    vecs[2] = '{2'd3, 2'd3, 4'd15, 1'b0, 1'b0, 1'b0, 4,  28, 10, 29, 47, 0,  0,  0,  0,  49};
    vecs[3] = '{2'd0, 2'd2, 4'd1,  1'b0, 1'b0, 1'b1, 4,  28, 1,  29, 29, 0,  0,  31, 33, 34};
    vecs[4] = '{2'd1, 2'd0, 4'd0,  1'b1, 1'b1, 1'b0, 8,  16, 0,  0,  0,  17, 22, 0,  0,  23};

    reset        = 1'b0;
    bus.inicio   = 1'b0;
    bus.cancelar = 1'b0;
    apply_cfg(2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset ocupado", int'(bus.ocupado), 0);
    check("reset listo", int'(bus.listo), 0);
    check("reset actuators", actuators(), 0);
    check("reset tipo_activo", int'(bus.tipo_activo), 0);
`ifdef CONTADOR_BEBIDAS_EN
    check("reset total_bebidas", int'(bus.total_bebidas), 0);
`endif
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) run_drink(i, vecs[i]);

    // Cancel on the 6th water cycle of a medium drink (water spans cycles 5..20).
    start(2'd1, 1'b0);
    repeat (9) @(negedge clock);
    check("cancel agua before", int'(bus.agua), 1);
    bus.cancelar = 1'b1;
    @(negedge clock);
    bus.cancelar = 1'b0;
    check("cancel agua after", int'(bus.agua), 0);
    check("cancel ocupado", int'(bus.ocupado), 0);
    check("cancel listo", int'(bus.listo), 0);
    @(negedge clock);
    check("cancel listo later", int'(bus.listo), 0);
    check("cancel actuators later", actuators(), 0);

    // Cancel on the last grind cycle wins over the MOLER->AGUA transition.
    start(2'd0, 1'b0);
    repeat (3) @(negedge clock);
    check("cancel moler last", int'(bus.moler), 1);
    bus.cancelar = 1'b1;
    @(negedge clock);
    bus.cancelar = 1'b0;
    check("cancel priority agua", int'(bus.agua), 0);
    check("cancel priority ocupado", int'(bus.ocupado), 0);

    // inicio and cancelar together in IDLE: start is refused.
    bus.inicio   = 1'b1;
    bus.cancelar = 1'b1;
    @(negedge clock);
    bus.inicio   = 1'b0;
    bus.cancelar = 1'b0;
    check("idle inicio+cancelar ocupado", int'(bus.ocupado), 0);
    check("idle inicio+cancelar moler", int'(bus.moler), 0);

    run_drink(5, vecs[0]);

`ifdef CONTADOR_BEBIDAS_EN
    check("total_bebidas", int'(bus.total_bebidas), 6);
`endif

    // Asynchronous reset in the middle of the milk phase.
    begin
      int found = 0;
      @(negedge clock);
      apply_cfg(2'd2, 2'd1, 4'd3, 1'b1, 1'b1, 1'b1);
      bus.inicio = 1'b1;
      for (int cyc = 1; cyc <= 100; cyc++) begin
        @(negedge clock);
        bus.inicio = 1'b0;
        if (bus.valvula_leche) begin
          found = 1;
          break;
        end
      end
      check("reach leche", found, 1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("async reset ocupado", int'(bus.ocupado), 0);
      check("async reset leche", int'(bus.valvula_leche), 0);
      check("async reset actuators", actuators(), 0);
      check("async reset tipo_activo", int'(bus.tipo_activo), 0);
`ifdef CONTADOR_BEBIDAS_EN
      check("async reset total_bebidas", int'(bus.total_bebidas), 0);
`endif
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("post reset ocupado", int'(bus.ocupado), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
